sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single 8-phase SDRAM controller slot between three requesters: port 0 (video, read-only, fixed highest priority), port 1 (CPU) and port 2 (ROM loader / DMA).
- Tracks the controller's phase from clkref and grants at most one access per SDRAM cycle.
- Holds the winner's address, data, strobes and oe/we stable for the whole cycle, then returns read data with a one-clock ack.
- Sits between the chipset/CPU and the SDRAM controller, in the same clk domain.

Parameters:
- READ_PHASE, 3'd7, phase at whose clock edge sd_dout is captured and ack is issued (CAS latency 3, RAS-CAS 3).
- REFRESH_INTERVAL, 8'd32, SDRAM cycles between forced idle cycles (used only with the optional feature).

Ports:
- clk  in  1  SDRAM clock (same as controller).
- reset  in  1  synchronous, active-high.
- clkref  in  1  controller reference clock, same signal the controller syncs to.
- req0 / req1 / req2  in  1 each  single-clock request strobe.
- we1, we2  in  1 each  1 = write; port 0 is always a read.
- addr0, addr1, addr2  in  25 each  word address.
- din1, din2  in  16 each  write data.
- uds1, lds1, uds2, lds2  in  1 each  byte strobes; port 0 uses both bytes.
- ack0 / ack1 / ack2  out  1 each  one-clock completion pulse.
- rdata  out  16  read data, valid while the matching ack is high and held until the next capture.
- sd_addr  out  25  to controller addr.
- sd_din  out  16  to controller din.
- sd_uds, sd_lds  out  1 each  to controller strobes.
- sd_oe, sd_we  out  1 each  to controller oe/we.
- sd_dout  in  16  from controller dout.

Behaviour:
- Phase counter ph[2:0] mirrors the controller:
  - At ph==7, advance only when clkref==0.
  - At ph==0, advance only when clkref==1.
  - Otherwise always increment; wraps 7 to 0.
- Pending bits p0..p2: set on reqN; cleared when ackN fires. A reqN while pN is already set is ignored. Latched fields (addr, din, we, strobes) are captured with each accepted req.
- Grant, on the clock edge where ph==7 and ph advances (the cycle boundary):
  - Eligible set = pending bits plus any req arriving on that same edge.
  - Port 0 wins if eligible.
  - Otherwise ports 1 and 2 round-robin: the last-served of the two gets lower priority; reset state favours port 1.
  - Winner's fields are registered onto the sd_* outputs. sd_oe = ~we, sd_we = we.
  - No eligible port: sd_oe = sd_we = 0, which makes the controller issue auto-refresh.
- sd_* outputs are stable from that edge until the next boundary.
- Completion, on the edge where ph==READ_PHASE and a grant is active:
  - rdata <= sd_dout for reads; rdata is unchanged for writes.
  - ackN = 1 for exactly one clk.
  - Pending bit cleared; grant marked inactive.
  - If the completion edge coincides with the boundary edge, the new grant is taken on the same edge. A port cannot be regranted for the request being acked.
- Latency (idle system): a req accepted before the boundary edge gives ack at the next ph==READ_PHASE, i.e. at most 16 clk after req (plus clkref stretch).
- ph stalls at 0 or 7 while waiting for clkref; outputs hold throughout.
- Reset (including mid-access), on the next edge: ph=0, p*=0, ack*=0, rdata=0, sd_oe=sd_we=0, sd_addr=0, sd_din=0, sd_uds=sd_lds=0, round-robin favours port 1. The in-flight access is dropped with no ack.

Optional Feature:
- Macro: SDRAM_ARB_REFRESH_EN.
- Defined: an 8-bit cycle counter increments every boundary. When it reaches REFRESH_INTERVAL-1, that boundary grants nothing, the counter resets to 0 and pending requests wait one cycle. Any boundary that was already idle also resets the counter.
- Undefined: no counter; refresh happens only on naturally idle cycles.

Test Plan:
- Single read: req1 with addr1=25'h000123, we1=0, sd_dout model returns 16'hBEEF at ph 7 -> sd_addr=25'h000123 and sd_oe=1 for one full cycle, ack1 one clk, rdata=16'hBEEF, ack0 and ack2 stay 0.
- Priority: req0, req1, req2 in the same clk -> acks in the order port 0, port 1, port 2 over three consecutive SDRAM cycles; req0 re-pulsed each cycle -> port 0 every cycle, ports 1 and 2 starved.
- Round robin: p1 and p2 held pending continuously (re-requested after each ack), port 0 idle -> grants alternate 1,2,1,2.
- Write: req2, we2=1, din2=16'h55AA, uds2=0, lds2=1 -> sd_we=1, sd_din=16'h55AA, sd_uds=0, sd_lds=1, ack2 pulse, rdata unchanged.
- Reset mid-access: reset asserted at ph 4 of a granted read -> no ack; next clk sd_oe=0 and all pending bits 0; a req after reset is served normally.
- With SDRAM_ARB_REFRESH_EN and REFRESH_INTERVAL=4, port 1 continuously pending -> every 4th cycle has sd_oe=sd_we=0; without the macro, every cycle is granted.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one 8-phase SDRAM controller slot between video (port 0), CPU (port 1) and loader/DMA (port 2).
// Optional macro SDRAM_ARB_REFRESH_EN forces an idle (auto-refresh) cycle every REFRESH_INTERVAL SDRAM cycles.
module sdram_arbiter #(
  parameter logic [2:0] READ_PHASE       = 3'd7,
  parameter logic [7:0] REFRESH_INTERVAL = 8'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkref,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic        we1,
  input  logic        we2,
  input  logic [24:0] addr0,
  input  logic [24:0] addr1,
  input  logic [24:0] addr2,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic        uds1,
  input  logic        lds1,
  input  logic        uds2,
  input  logic        lds2,
  output logic        ack0,
  output logic        ack1,
  output logic        ack2,
  output logic [15:0] rdata,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic        sd_uds,
  output logic        sd_lds,
  output logic        sd_oe,
  output logic        sd_we,
  input  logic [15:0] sd_dout
);

  logic [2:0]       ph_q, ph_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0][24:0] addr_q, addr_d;
  logic [2:0][15:0] din_q, din_d;
  logic [2:0]       we_q, we_d, uds_q, uds_d, lds_q, lds_d;
  logic             active_q, active_d;
  logic [1:0]       port_q, port_d;
  logic             fav2_q, fav2_d;
  logic [2:0]       ack_q, ack_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [24:0]      sd_addr_q, sd_addr_d;
  logic [15:0]      sd_din_q, sd_din_d;
  logic             sd_uds_q, sd_uds_d, sd_lds_q, sd_lds_d;
  logic             sd_oe_q, sd_oe_d, sd_we_q, sd_we_d;

  logic [2:0]       req_v, acc, done, elig;
  logic [2:0][24:0] in_addr;
  logic [2:0][15:0] in_din;
  logic [2:0]       in_we, in_uds, in_lds;
  logic             adv, bnd, cmp, gnt, force_idle;
  logic [1:0]       win;

  // Port 0 is a read-only, full-word requester.
  assign req_v   = {req2, req1, req0};
  assign in_addr = {addr2, addr1, addr0};
  assign in_din  = {din2, din1, 16'h0000};
  assign in_we   = {we2, we1, 1'b0};
  assign in_uds  = {uds2, uds1, 1'b1};
  assign in_lds  = {lds2, lds1, 1'b1};

`ifdef SDRAM_ARB_REFRESH_EN
  logic [7:0] rcnt_q, rcnt_d;

  assign force_idle = (rcnt_q == REFRESH_INTERVAL - 8'd1);

  // Every idle boundary refreshes, so it also restarts the interval.
  always_comb begin
    rcnt_d = rcnt_q;
    if (bnd) rcnt_d = gnt ? rcnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) rcnt_q <= 8'd0;
    else       rcnt_q <= rcnt_d;
  end
`else
  logic [7:0] unused_refresh_interval;
  assign unused_refresh_interval = REFRESH_INTERVAL;
  assign force_idle = 1'b0;
`endif

  always_comb begin
    adv  = (ph_q == 3'd7) ? ~clkref : (ph_q == 3'd0) ? clkref : 1'b1;
    bnd  = (ph_q == 3'd7) & ~clkref;
    cmp  = (ph_q == READ_PHASE) & active_q;
    ph_d = adv ? ph_q + 3'd1 : ph_q;

    // A port being acked on this edge is still pending, so its new req is dropped
    // and it cannot win the boundary that coincides with its ack.
    acc    = req_v & ~pend_q;
    done   = cmp ? (3'b001 << port_q) : 3'b000;
    pend_d = (pend_q | acc) & ~done;

    addr_d = addr_q;
    din_d  = din_q;
    we_d   = we_q;
    uds_d  = uds_q;
    lds_d  = lds_q;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        addr_d[i] = in_addr[i];
        din_d[i]  = in_din[i];
        we_d[i]   = in_we[i];
        uds_d[i]  = in_uds[i];
        lds_d[i]  = in_lds[i];
      end
    end

    elig = force_idle ? 3'b000 : pend_d;
    gnt  = bnd & (|elig);
    if (elig[0])                           win = 2'd0;
    else if (elig[1] & (~elig[2] | ~fav2_q)) win = 2'd1;
    else                                   win = 2'd2;

    active_d  = cmp ? 1'b0 : active_q;
    port_d    = port_q;
    fav2_d    = fav2_q;
    ack_d     = done;
    rdata_d   = (cmp & ~sd_we_q) ? sd_dout : rdata_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_uds_d  = sd_uds_q;
    sd_lds_d  = sd_lds_q;
    sd_oe_d   = sd_oe_q;
    sd_we_d   = sd_we_q;

    if (bnd) begin
      sd_oe_d = 1'b0;
      sd_we_d = 1'b0;
      if (gnt) begin
        active_d  = 1'b1;
        port_d    = win;
        sd_addr_d = addr_d[win];
        sd_din_d  = din_d[win];
        sd_uds_d  = uds_d[win];
        sd_lds_d  = lds_d[win];
        sd_we_d   = we_d[win];
        sd_oe_d   = ~we_d[win];
        if (win == 2'd1)      fav2_d = 1'b1;
        else if (win == 2'd2) fav2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q      <= 3'd0;
      pend_q    <= 3'b000;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 3'b000;
      uds_q     <= 3'b000;
      lds_q     <= 3'b000;
      active_q  <= 1'b0;
      port_q    <= 2'd0;
      fav2_q    <= 1'b0;
      ack_q     <= 3'b000;
      rdata_q   <= 16'h0000;
      sd_addr_q <= 25'd0;
      sd_din_q  <= 16'h0000;
      sd_uds_q  <= 1'b0;
      sd_lds_q  <= 1'b0;
      sd_oe_q   <= 1'b0;
      sd_we_q   <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      active_q  <= active_d;
      port_q    <= port_d;
      fav2_q    <= fav2_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      sd_addr_q <= sd_addr_d;
      sd_din_q  <= sd_din_d;
      sd_uds_q  <= sd_uds_d;
      sd_lds_q  <= sd_lds_d;
      sd_oe_q   <= sd_oe_d;
      sd_we_q   <= sd_we_d;
    end
  end

  assign ack0    = ack_q[0];
  assign ack1    = ack_q[1];
  assign ack2    = ack_q[2];
  assign rdata   = rdata_q;
  assign sd_addr = sd_addr_q;
  assign sd_din  = sd_din_q;
  assign sd_uds  = sd_uds_q;
  assign sd_lds  = sd_lds_q;
  assign sd_oe   = sd_oe_q;
  assign sd_we   = sd_we_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic against a transaction-rule model.
module tb_sdram_arbiter;
  localparam logic [2:0] RP = 3'd7;
  localparam int         RI = 4;

  logic        clk = 1'b0, reset = 1'b1, clkref = 1'b1;
  logic        req0 = 0, req1 = 0, req2 = 0, we1 = 0, we2 = 0;
  logic [24:0] addr0 = 0, addr1 = 0, addr2 = 0;
  logic [15:0] din1 = 0, din2 = 0, sd_dout = 0;
  logic        uds1 = 1, lds1 = 1, uds2 = 1, lds2 = 1;
  logic        ack0, ack1, ack2, sd_uds, sd_lds, sd_oe, sd_we;
  logic [15:0] rdata, sd_din;
  logic [24:0] sd_addr;

  int total = 0, bad = 0;
  bit rnd_ck = 0, stretch = 0, ph7_seen = 0;

  sdram_arbiter #(.READ_PHASE(RP), .REFRESH_INTERVAL(8'(RI))) dut (
    .clk(clk), .reset(reset), .clkref(clkref),
    .req0(req0), .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .din1(din1), .din2(din2),
    .uds1(uds1), .lds1(lds1), .uds2(uds2), .lds2(lds2),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .rdata(rdata),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_uds(sd_uds), .sd_lds(sd_lds),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_dout(sd_dout));

  always #5 clk = ~clk;

  // Reference model: one SDRAM slot, phase rules, pending set, grant-at-boundary.
  bit [2:0]  m_ph, m_pend, m_ack;
  bit [24:0] m_addr[3];
  bit [15:0] m_din[3];
  bit        m_we[3], m_uds[3], m_lds[3];
  bit        m_active, m_fav2;
  int        m_port, m_rcnt;
  bit [15:0] m_rdata, m_sd_din;
  bit [24:0] m_sd_addr;
  bit        m_sd_uds, m_sd_lds, m_sd_oe, m_sd_we;

  task automatic model_step();
    bit adv, skip;
    bit [2:0] reqv, was;
    int win;
    if (reset) begin
      m_ph = 0; m_pend = 0; m_ack = 0; m_rdata = 0; m_active = 0; m_fav2 = 0; m_rcnt = 0;
      m_sd_addr = 0; m_sd_din = 0; m_sd_uds = 0; m_sd_lds = 0; m_sd_oe = 0; m_sd_we = 0;
      return;
    end
    adv  = (m_ph == 7) ? !clkref : (m_ph == 0) ? clkref : 1'b1;
    reqv = {req2, req1, req0};
    was  = m_pend;
    m_ack = 0;
    if (m_ph == RP && m_active) begin
      m_ack[m_port] = 1; m_pend[m_port] = 0; m_active = 0;
      if (!m_sd_we) m_rdata = sd_dout;
    end
    for (int i = 0; i < 3; i++) begin
      if (reqv[i] && !was[i]) begin
        m_pend[i] = 1;
        case (i)
          0: begin m_addr[0] = addr0; m_din[0] = 0;    m_we[0] = 0;   m_uds[0] = 1;    m_lds[0] = 1;    end
          1: begin m_addr[1] = addr1; m_din[1] = din1; m_we[1] = we1; m_uds[1] = uds1; m_lds[1] = lds1; end
          default: begin m_addr[2] = addr2; m_din[2] = din2; m_we[2] = we2; m_uds[2] = uds2; m_lds[2] = lds2; end
        endcase
      end
    end
    if (m_ph == 7 && adv) begin
      win = -1;
      skip = 0;
`ifdef SDRAM_ARB_REFRESH_EN
      if (m_rcnt == RI - 1) skip = 1;
`endif
      if (!skip) begin
        if (m_pend[0]) win = 0;
        else if (m_pend[1] && m_pend[2]) win = m_fav2 ? 2 : 1;
        else if (m_pend[1]) win = 1;
        else if (m_pend[2]) win = 2;
      end
      if (win < 0) begin
        m_sd_oe = 0; m_sd_we = 0; m_rcnt = 0;
      end else begin
        m_active = 1; m_port = win; m_rcnt++;
        m_sd_addr = m_addr[win]; m_sd_din = m_din[win];
        m_sd_uds = m_uds[win]; m_sd_lds = m_lds[win];
        m_sd_we = m_we[win]; m_sd_oe = !m_we[win];
        if (win == 1) m_fav2 = 1;
        if (win == 2) m_fav2 = 0;
      end
    end
    if (adv) m_ph = m_ph + 3'd1;
  endtask

  always @(posedge clk) model_step();

  // One clk: edge, then clear strobes and choose clkref for the next edge.
  task automatic step();
    @(posedge clk); #1;
    req0 = 0; req1 = 0; req2 = 0;
    if (rnd_ck) clkref = 1'($urandom_range(0, 1));
    else if (stretch && m_ph == 7) begin clkref = ph7_seen ? 1'b0 : 1'b1; ph7_seen = 1; end
    else begin clkref = (m_ph <= 3); ph7_seen = 0; end
  endtask

  task automatic test_reset();
    int n_ack;
    reset = 1; req1 = 1; addr1 = 25'h1FFFFFF;
    step(); step();
    total++; if ({ack2, ack1, ack0} !== 3'b000) begin bad++; $display("FAIL reset_ack: got %b want 000", {ack2, ack1, ack0}); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    total++; if (sd_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", sd_oe); end
    total++; if (sd_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", sd_we); end
    total++; if (sd_addr !== 25'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sd_addr); end
    total++; if (sd_din !== 16'h0) begin bad++; $display("FAIL reset_din: got %h want 0", sd_din); end
    total++; if ({sd_uds, sd_lds} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {sd_uds, sd_lds}); end
    reset = 0;
    n_ack = 0;
    for (int n = 0; n < 20; n++) begin step(); if (ack0 | ack1 | ack2 | sd_oe) n_ack++; end
    total++; if (n_ack != 0) begin bad++; $display("FAIL reset_idle: got %0d activity want 0", n_ack); end
  endtask

  task automatic test_priority();
    int order[$], tms[$], n0, n12;
    sd_dout = 16'hBEEF;
    addr0 = 25'h10; addr1 = 25'h11; addr2 = 25'h12; we1 = 0; we2 = 0;
    req0 = 1; req1 = 1; req2 = 1;
    for (int n = 0; n < 60; n++) begin
      step();
      if (ack0) begin order.push_back(0); tms.push_back(n); end
      if (ack1) begin order.push_back(1); tms.push_back(n); end
      if (ack2) begin order.push_back(2); tms.push_back(n); end
    end
    total++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      bad++; $display("FAIL prio_order: got %p want 0 1 2", order);
    end else begin
      total++;
      if (tms[1] - tms[0] != 8 || tms[2] - tms[1] != 8) begin
        bad++; $display("FAIL prio_spacing: got %0d,%0d want 8,8", tms[1] - tms[0], tms[2] - tms[1]);
      end
    end
    // Port 0 re-requested every clk starves ports 1 and 2.
    stretch = 1; n0 = 0; n12 = 0;
    req1 = 1; req2 = 1;
    for (int n = 0; n < 60; n++) begin
      req0 = 1; step();
      if (ack0) n0++;
      if (ack1 | ack2) n12++;
    end
    total++; if (n0 < 5) begin bad++; $display("FAIL starve_p0: got %0d acks want >=5", n0); end
    total++; if (n12 != 0) begin bad++; $display("FAIL starve_p12: got %0d acks want 0", n12); end
    order.delete();
    for (int n = 0; n < 60; n++) begin
      step();
      if (ack1) order.push_back(1);
      if (ack2) order.push_back(2);
    end
    total++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 2) begin
      bad++; $display("FAIL starve_drain: got %p want 1 2", order);
    end
    stretch = 0;
  endtask

  task automatic test_single_read();
    int oe_cnt, n1, n_other, lat;
    bit [15:0] rd;
    sd_dout = 16'hBEEF;
    addr1 = 25'h000123; we1 = 0; uds1 = 1; lds1 = 1; req1 = 1;
    oe_cnt = 0; n1 = 0; n_other = 0; lat = -1; rd = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (sd_oe && !sd_we && sd_addr == 25'h000123) oe_cnt++;
      if (ack1) begin n1++; rd = rdata; if (lat < 0) lat = n; end
      if (ack0 | ack2) n_other++;
    end
    total++; if (n1 != 1) begin bad++; $display("FAIL read_ack1: got %0d pulses want 1", n1); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL read_rdata: got %h want beef", rd); end
    total++; if (oe_cnt != 8) begin bad++; $display("FAIL read_oe_cycle: got %0d clk want 8", oe_cnt); end
    total++; if (lat < 1 || lat > 16) begin bad++; $display("FAIL read_latency: got %0d want 1..16", lat); end
    total++; if (n_other != 0) begin bad++; $display("FAIL read_other_ack: got %0d want 0", n_other); end
  endtask

  task automatic test_round_robin();
    int order[$];
    bit alt_ok;
    stretch = 1;
    we1 = 0; we2 = 0; addr1 = 25'h21; addr2 = 25'h22;
    req1 = 1; req2 = 1;
    for (int n = 0; n < 80; n++) begin
      step();
      if (ack1) begin order.push_back(1); req1 = 1; end
      if (ack2) begin order.push_back(2); req2 = 1; end
    end
    for (int n = 0; n < 40; n++) step();
    stretch = 0;
    total++;
    if (order.size() < 6) begin
      bad++; $display("FAIL rr_count: got %0d acks want >=6", order.size());
    end else begin
      alt_ok = 1;
      for (int i = 1; i < order.size(); i++) if (order[i] == order[i-1]) alt_ok = 0;
      total++; if (order[0] != 2) begin bad++; $display("FAIL rr_first: got %0d want 2", order[0]); end
      total++; if (!alt_ok) begin bad++; $display("FAIL rr_alternate: got %p want alternating 1/2", order); end
    end
  endtask

  task automatic test_write();
    bit seen;
    bit [15:0] w_din, rd;
    bit [24:0] w_addr;
    bit w_uds, w_lds, w_oe;
    int n2;
    sd_dout = 16'h1234;
    addr2 = 25'h1ABCDEF; we2 = 1; din2 = 16'h55AA; uds2 = 0; lds2 = 1; req2 = 1;
    seen = 0; n2 = 0; rd = 0; w_din = 0; w_addr = 0; w_uds = 1; w_lds = 0; w_oe = 1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (sd_we && !seen) begin seen = 1; w_din = sd_din; w_addr = sd_addr; w_uds = sd_uds; w_lds = sd_lds; w_oe = sd_oe; end
      if (ack2) begin n2++; rd = rdata; end
    end
    total++; if (!seen) begin bad++; $display("FAIL write_we: got no sd_we want 1"); end
    total++; if (w_din !== 16'h55AA) begin bad++; $display("FAIL write_din: got %h want 55aa", w_din); end
    total++; if (w_addr !== 25'h1ABCDEF) begin bad++; $display("FAIL write_addr: got %h want 1abcdef", w_addr); end
    total++; if ({w_uds, w_lds} !== 2'b01) begin bad++; $display("FAIL write_strobes: got %b want 01", {w_uds, w_lds}); end
    total++; if (w_oe !== 1'b0) begin bad++; $display("FAIL write_oe: got %b want 0", w_oe); end
    total++; if (n2 != 1) begin bad++; $display("FAIL write_ack2: got %0d want 1", n2); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL write_rdata: got %h want beef", rd); end
    we2 = 0; uds2 = 1;
  endtask

  task automatic test_reset_mid();
    bit found, granted;
    int act, n1;
    bit [15:0] rd;
    sd_dout = 16'hC0DE;
    addr1 = 25'h42; we1 = 0; req1 = 1;
    found = 0; granted = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (sd_oe && !granted) begin granted = 1; req2 = 1; addr2 = 25'h99; we2 = 0; end
      if (granted && m_ph == 4) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_setup: got no grant at ph4 want grant"); end
    reset = 1; step(); reset = 0;
    total++; if ({sd_oe, sd_we, ack0, ack1, ack2} !== 5'b0) begin
      bad++; $display("FAIL rstmid_outputs: got %b want 00000", {sd_oe, sd_we, ack0, ack1, ack2});
    end
    act = 0;
    for (int n = 0; n < 30; n++) begin step(); if (ack0 | ack1 | ack2 | sd_oe) act++; end
    total++; if (act != 0) begin bad++; $display("FAIL rstmid_dropped: got %0d activity want 0", act); end
    addr1 = 25'h77; req1 = 1; n1 = 0; rd = 0;
    for (int n = 0; n < 30; n++) begin step(); if (ack1) begin n1++; rd = rdata; end end
    total++; if (n1 != 1 || rd !== 16'hC0DE) begin
      bad++; $display("FAIL rstmid_after: got %0d acks rdata %h want 1 acks rdata c0de", n1, rd);
    end
  endtask

  task automatic test_refresh();
    bit g[12];
    int ns, idle, wt;
    bit ok;
    stretch = 1; addr1 = 25'h33; we1 = 0;
    wt = 0;
    while (!ack1 && wt < 40) begin req1 = 1; step(); wt++; end
    total++; if (!ack1) begin bad++; $display("FAIL refresh_start: got no ack1 want ack1"); end
    ns = 0; wt = 0;
    while (ns < 12 && wt < 200) begin
      req1 = 1; step(); wt++;
      if (m_ph == 3) begin g[ns] = sd_oe | sd_we; ns++; end
    end
    for (int n = 0; n < 40; n++) step();
    stretch = 0;
    idle = 0;
    for (int i = 0; i < 12; i++) if (!g[i]) idle++;
`ifdef SDRAM_ARB_REFRESH_EN
    ok = 1;
    for (int i = 0; i < 8; i++) if (g[i] != g[i+4]) ok = 0;
    total++; if (idle != 3) begin bad++; $display("FAIL refresh_idle: got %0d idle want 3", idle); end
    total++; if (!ok) begin bad++; $display("FAIL refresh_period: got nonperiodic idles want period 4"); end
`else
    ok = (ns == 12);
    total++; if (idle != 0 || !ok) begin bad++; $display("FAIL refresh_none: got %0d idle of %0d want 0 of 12", idle, ns); end
`endif
  endtask

  task automatic test_random();
    rnd_ck = 1;
    for (int n = 0; n < 2000; n++) begin
      req0 = ($urandom_range(0, 5) == 0); req1 = ($urandom_range(0, 3) == 0); req2 = ($urandom_range(0, 3) == 0);
      addr0 = 25'($urandom); addr1 = 25'($urandom); addr2 = 25'($urandom);
      din1 = 16'($urandom); din2 = 16'($urandom); sd_dout = 16'($urandom);
      we1 = 1'($urandom); we2 = 1'($urandom);
      uds1 = 1'($urandom); lds1 = 1'($urandom); uds2 = 1'($urandom); lds2 = 1'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      step();
      reset = 0;
      total++;
      if ({ack2, ack1, ack0, rdata, sd_oe, sd_we} !== {m_ack, m_rdata, m_sd_oe, m_sd_we}) begin
        bad++;
        $display("FAIL rnd_ctl@%0d: got ack=%b rd=%h oe=%b we=%b want ack=%b rd=%h oe=%b we=%b", n,
                 {ack2, ack1, ack0}, rdata, sd_oe, sd_we, m_ack, m_rdata, m_sd_oe, m_sd_we);
      end
      if (m_sd_oe || m_sd_we) begin
        total++;
        if ({sd_addr, sd_uds, sd_lds} !== {m_sd_addr, m_sd_uds, m_sd_lds} || (m_sd_we && sd_din !== m_sd_din)) begin
          bad++;
          $display("FAIL rnd_bus@%0d: got a=%h d=%h s=%b%b want a=%h d=%h s=%b%b", n,
                   sd_addr, sd_din, sd_uds, sd_lds, m_sd_addr, m_sd_din, m_sd_uds, m_sd_lds);
        end
      end
    end
    rnd_ck = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_single_read();
    test_round_robin();
    test_write();
    test_reset_mid();
    test_refresh();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
